// File: rtl/regfile_write_ctrl.sv
// Write-port controller for the 32x32 register file: clears all registers after reset,
// then shares the single write port between core writeback and a debug channel.
module regfile_write_ctrl #(
  parameter int NREGS      = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_we,
  input  logic [4:0]        core_rd,
  input  logic [DATA_W-1:0] core_wd,
  input  logic              dbg_valid,
  input  logic [4:0]        dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  output logic              dbg_ready,
  output logic              stall,
  output logic              init_done,
  output logic              rf_we,
  output logic [4:0]        rf_a3,
  output logic [DATA_W-1:0] rf_wd
);

  // state  | meaning
  // INIT   | clear sweep, one register per cycle, core stalled
  // RUN    | core writeback has priority, debug takes the port when core is idle
  // FORCE  | one-cycle debug slot after starvation, core stalled
  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_RUN   = 2'd1,
    S_FORCE = 2'd2
  } state_t;

  localparam logic [4:0] LAST_IDX   = 5'(NREGS - 1);
  localparam logic [3:0] STARVE_CNT = 4'(STARVE_MAX);

  state_t     state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cnt_inc;
  logic       core_wr;
  logic       dbg_wr;

  // Writes to x0 are dropped so they never occupy the port.
  assign core_wr = core_we && (core_rd != 5'd0);
  assign dbg_wr  = dbg_valid && (dbg_addr != 5'd0);
  assign cnt_inc = cnt_q + 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_INIT;
      idx_q   <= 5'd0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_INIT: begin
        idx_d = idx_q + 5'd1;
        cnt_d = 4'd0;
        if (idx_q == LAST_IDX) begin
          state_d = S_RUN;
          idx_d   = 5'd0;
        end
      end
      S_RUN: begin
        if (dbg_valid && core_wr) begin
          if (cnt_inc == STARVE_CNT) begin
            state_d = S_FORCE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d = 4'd0;
        end
      end
      S_FORCE: begin
        state_d = S_RUN;
        cnt_d   = 4'd0;
      end
      default: begin
        state_d = S_INIT;
        idx_d   = 5'd0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs are gated by rst directly so an asserted reset takes effect without an edge.
  always_comb begin
    rf_we     = 1'b0;
    rf_a3     = 5'd0;
    rf_wd     = '0;
    stall     = 1'b1;
    dbg_ready = 1'b0;
    init_done = 1'b0;
    if (rst) begin
      case (state_q)
        S_INIT: begin
          rf_we = 1'b1;
          rf_a3 = idx_q;
        end
        S_RUN: begin
          init_done = 1'b1;
          stall     = 1'b0;
          if (core_wr) begin
            rf_we = 1'b1;
            rf_a3 = core_rd;
            rf_wd = core_wd;
          end else begin
            dbg_ready = 1'b1;
            rf_we     = dbg_wr;
            rf_a3     = dbg_addr;
            rf_wd     = dbg_data;
          end
        end
        S_FORCE: begin
          init_done = 1'b1;
          dbg_ready = 1'b1;
          rf_we     = dbg_wr;
          rf_a3     = dbg_addr;
          rf_wd     = dbg_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed bench for regfile_write_ctrl; a behavioural register array captures the write port.
module tb_regfile_write_ctrl;

  logic        clk;
  logic        rst;
  logic        core_we;
  logic [4:0]  core_rd;
  logic [31:0] core_wd;
  logic        dbg_valid;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        dbg_ready;
  logic        stall;
  logic        init_done;
  logic        rf_we;
  logic [4:0]  rf_a3;
  logic [31:0] rf_wd;

  logic [31:0] rf [32];
  int checks;
  int failures;

  regfile_write_ctrl #(.NREGS(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .core_we   (core_we),
    .core_rd   (core_rd),
    .core_wd   (core_wd),
    .dbg_valid (dbg_valid),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .dbg_ready (dbg_ready),
    .stall     (stall),
    .init_done (init_done),
    .rf_we     (rf_we),
    .rf_a3     (rf_a3),
    .rf_wd     (rf_wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_we) rf[rf_a3] <= rf_wd;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Commit the current cycle, land on the next falling edge.
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_we"}, 32'(rf_we), 32'd0);
    check_eq({tag, "_a3"}, 32'(rf_a3), 32'd0);
    check_eq({tag, "_wd"}, rf_wd, 32'd0);
    check_eq({tag, "_stall"}, 32'(stall), 32'd1);
    check_eq({tag, "_rdy"}, 32'(dbg_ready), 32'd0);
    check_eq({tag, "_done"}, 32'(init_done), 32'd0);
  endtask

  task automatic run_sweep();
    int bad;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      #1;
      if (rf_we !== 1'b1 || rf_a3 !== 5'(i) || rf_wd !== 32'd0 || stall !== 1'b1) bad++;
      next_cycle();
    end
    check_eq("sweep_bad_cycles", 32'(bad), 32'd0);
    #1;
    check_eq("post_sweep_done", 32'(init_done), 32'd1);
    check_eq("post_sweep_stall", 32'(stall), 32'd0);
  endtask

  initial begin
    int nz;
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    core_we   = 1'b0;
    core_rd   = 5'd0;
    core_wd   = 32'd0;
    dbg_valid = 1'b0;
    dbg_addr  = 5'd0;
    dbg_data  = 32'd0;
    for (int i = 0; i < 32; i++) rf[i] = 32'hBAD0_0000 | 32'(i);

    #1;
    check_reset_outputs("rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    run_sweep();
    nz = 0;
    for (int i = 0; i < 32; i++) if (rf[i] !== 32'd0) nz++;
    check_eq("cleared_regs_nonzero", 32'(nz), 32'd0);

    // Core priority over a pending debug write.
    core_we = 1'b1; core_rd = 5'd5; core_wd = 32'hDEAD_BEEF;
    dbg_valid = 1'b1; dbg_addr = 5'd7; dbg_data = 32'h0000_0077;
    #1;
    check_eq("prio_a3", 32'(rf_a3), 32'd5);
    check_eq("prio_wd", rf_wd, 32'hDEAD_BEEF);
    check_eq("prio_rdy", 32'(dbg_ready), 32'd0);
    next_cycle();
    core_we = 1'b0;
    #1;
    check_eq("dbg_rdy", 32'(dbg_ready), 32'd1);
    check_eq("dbg_we", 32'(rf_we), 32'd1);
    check_eq("dbg_a3", 32'(rf_a3), 32'd7);
    next_cycle();
    dbg_valid = 1'b0;
    check_eq("x5_val", rf[5], 32'hDEAD_BEEF);
    check_eq("x7_val", rf[7], 32'h0000_0077);

    // x0 handling: core write to x0 frees the port, debug write to x0 is a no-op.
    core_we = 1'b1; core_rd = 5'd0; core_wd = 32'hFFFF_FFFF;
    #1;
    check_eq("core_x0_we", 32'(rf_we), 32'd0);
    check_eq("core_x0_rdy", 32'(dbg_ready), 32'd1);
    dbg_valid = 1'b1; dbg_addr = 5'd0; dbg_data = 32'hCAFE_F00D;
    #1;
    check_eq("dbg_x0_rdy", 32'(dbg_ready), 32'd1);
    check_eq("dbg_x0_we", 32'(rf_we), 32'd0);
    next_cycle();
    core_we = 1'b0; dbg_valid = 1'b0;
    check_eq("x0_val", rf[0], 32'd0);

    // Starvation: four blocked cycles, then a forced slot, then core resumes.
    core_we = 1'b1; core_rd = 5'd3; core_wd = 32'h3333_0003;
    dbg_valid = 1'b1; dbg_addr = 5'd9; dbg_data = 32'h0000_1234;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("starve_blk%0d_rdy", i), 32'(dbg_ready), 32'd0);
      check_eq($sformatf("starve_blk%0d_stall", i), 32'(stall), 32'd0);
      check_eq($sformatf("starve_blk%0d_a3", i), 32'(rf_a3), 32'd3);
      next_cycle();
    end
    #1;
    check_eq("force_stall", 32'(stall), 32'd1);
    check_eq("force_rdy", 32'(dbg_ready), 32'd1);
    check_eq("force_we", 32'(rf_we), 32'd1);
    check_eq("force_a3", 32'(rf_a3), 32'd9);
    check_eq("force_wd", rf_wd, 32'h0000_1234);
    next_cycle();
    dbg_valid = 1'b0;
    #1;
    check_eq("resume_stall", 32'(stall), 32'd0);
    check_eq("resume_a3", 32'(rf_a3), 32'd3);
    check_eq("resume_wd", rf_wd, 32'h3333_0003);
    check_eq("x9_val", rf[9], 32'h0000_1234);
    next_cycle();

    // Forced slot with dbg_valid dropped: wasted slot, counter restarts from zero.
    dbg_valid = 1'b1; dbg_addr = 5'd11; dbg_data = 32'h0000_BBBB;
    repeat (4) next_cycle();
    dbg_valid = 1'b0;
    #1;
    check_eq("waste_stall", 32'(stall), 32'd1);
    check_eq("waste_we", 32'(rf_we), 32'd0);
    next_cycle();
    check_eq("waste_run_stall", 32'(stall), 32'd0);
    check_eq("x11_val", rf[11], 32'd0);
    dbg_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq($sformatf("cnt_clr%0d_stall", i), 32'(stall), 32'd0);
      next_cycle();
    end
    #1;
    check_eq("cnt_clr_force", 32'(stall), 32'd1);
    next_cycle();
    core_we = 1'b0; dbg_valid = 1'b0;

    // Reset mid-sweep: asynchronous abort, then a fresh sweep from register 0.
    rst = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
    repeat (10) next_cycle();
    #1;
    check_eq("mid_idx10", 32'(rf_a3), 32'd10);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst = 1'b1;
    run_sweep();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1);
  end

endmodule

// File: doc/regfile_write_ctrl.md
# regfile_write_ctrl

Write-port controller for the 32x32 register file in the single-cycle RISC-V core. After reset it clears every register with a sequenced write sweep, because the register array itself has no reset. In normal running it shares the single write port (A3/WD3/WE3) between core writeback and a debug write channel. Core writeback has priority; a starvation counter guarantees debug progress by stalling the core for one cycle.

## Interface
Parameters:
- NREGS, 32, number of registers cleared by the init sweep; index width is 5 bits.
- DATA_W, 32, register data width.
- STARVE_MAX, 4, number of consecutive blocked debug cycles before a forced debug slot (legal range 1..15).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- core_we  input  1  core writeback enable.
- core_rd  input  5  core destination register.
- core_wd  input  DATA_W  core writeback data.
- dbg_valid  input  1  debug write request; held with addr/data until accepted.
- dbg_addr  input  5  debug target register.
- dbg_data  input  DATA_W  debug write data.
- dbg_ready  output  1  debug write accepted this cycle when dbg_valid=1 (combinational).
- stall  output  1  core must hold its PC and state; core_we is ignored while this is high.
- init_done  output  1  high once the clear sweep has completed.
- rf_we  output  1  to register file WE3.
- rf_a3  output  5  to register file A3.
- rf_wd  output  DATA_W  to register file WD3.

## Operation
- States: INIT, RUN, FORCE. Registers: 2-bit state, 5-bit sweep index idx, 4-bit starvation counter cnt.
- Reset (rst=0, asynchronous) sets state=INIT, idx=0, cnt=0. While rst=0, outputs are rf_we=0, rf_a3=0, rf_wd=0, stall=1, dbg_ready=0, init_done=0.
- INIT, with rst=1:
  - Drives rf_we=1, rf_a3=idx, rf_wd=0, stall=1, dbg_ready=0.
  - idx increments each cycle.
  - On the cycle idx=NREGS-1, next state is RUN.
- init_done=1 exactly when state is RUN or FORCE.
- RUN:
  - core_wr = core_we and core_rd!=0. A write to x0 is dropped and frees the port.
  - If core_wr: rf_we=1, rf_a3=core_rd, rf_wd=core_wd, dbg_ready=0.
  - Otherwise: dbg_ready=1, rf_we = dbg_valid and dbg_addr!=0, rf_a3=dbg_addr, rf_wd=dbg_data.
  - stall=0.
- Debug handshake:
  - A transfer occurs on an edge where dbg_valid=1 and dbg_ready=1.
  - A debug write to x0 completes the handshake but performs no write.
- Starvation:
  - In RUN, if dbg_valid=1 and core_wr=1, cnt increments. Otherwise cnt clears to 0.
  - If the incremented value equals STARVE_MAX, next state is FORCE and cnt clears to 0.
- FORCE (exactly one cycle):
  - stall=1, dbg_ready=1, core_we ignored.
  - rf_we = dbg_valid and dbg_addr!=0, rf_a3=dbg_addr, rf_wd=dbg_data.
  - Next state is RUN unconditionally, including when dbg_valid dropped (the slot is wasted with no write).
- All rf_* outputs and dbg_ready/stall are combinational from state, idx and inputs. There are no extra pipeline stages, so a granted write lands on the same edge the single-cycle datapath expects.
- Reset asserted mid-sweep or mid-FORCE aborts immediately. A fresh full sweep follows release.

## Timing
- Sweep: the first write happens on the first rising edge after rst goes high. Registers 0..31 are written on edges 1..32. init_done=1 and stall=0 from the cycle after edge 32.
- Core write latency: zero. It is passed through in the same cycle and committed at the next edge.
- Debug latency:
  - With no core conflict, a request is accepted in its first cycle.
  - Under continuous core writes, acceptance happens in the FORCE cycle: STARVE_MAX+1 cycles after dbg_valid rises.
- stall is high for exactly one cycle per forced slot.
- A debug transfer and a core write never occur in the same cycle. rf_we is never driven by two sources.

## Test plan
- Reset release: hold rst=0 for 3 cycles, then release. Expect rf_we=1 with rf_a3=0..31 and rf_wd=0 on 32 consecutive edges, then init_done=1 and stall=0. Read back of all registers is 0.
- Core priority:
  - core_we=1, rd=5, wd=0xDEADBEEF with dbg_valid=1, addr=7 → rf_a3=5, dbg_ready=0.
  - Next cycle core_we=0 → dbg_ready=1 and x7 is written.
- x0 handling:
  - core_we=1, rd=0 → rf_we=0 and dbg_ready=1.
  - Debug write to addr 0 → handshake completes, rf_we=0, x0 stays 0.
- Starvation (STARVE_MAX=4): core writes every cycle, dbg_valid held with addr=9, data=0x1234. Expect 4 blocked cycles, then a FORCE cycle with stall=1, dbg_ready=1, and x9=0x1234. Core resumes the next cycle with its held write.
- FORCE with dbg_valid dropped in that cycle: stall=1, rf_we=0, return to RUN, cnt=0.
- Reset mid-sweep: drop rst at idx=10. Outputs go to reset values immediately, without waiting for an edge. After release the sweep restarts at register 0.
